// File: rtl/mem_port_arbiter.sv
// Four-way arbiter sharing one single-port data memory among store, fetch,
// load1 and load2; returns read data to the requester that issued it.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   req[3:0]            bit0 store, bit1 fetch, bit2 load1, bit3 load2
//   addr0..addr3        per-requester address
//   wdata0              store data
//   gnt[3:0]            one-hot combinational grant
//   rdata1..rdata3      held read data per read requester
//   rvalid[3:0]         one-cycle read-return pulse (bit0 always 0)
//   mem_en/we/addr/wdata  memory command
//   mem_rdata           memory read data, one cycle after a read
module mem_port_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter bit STORE_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [ADDR_W-1:0] addr3,
  input  logic [DATA_W-1:0] wdata0,
  output logic [3:0]        gnt,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] rdata3,
  output logic [3:0]        rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0] ptr;
  logic       pend_v;
  logic [1:0] pend_tag;

  logic       hit;
  logic [1:0] win;
  logic [1:0] idx;
  logic       go;
  logic       rd_go;

  // Store override first, otherwise a rotating search starting at ptr.
  always_comb begin
    hit = 1'b0;
    win = 2'd0;
    idx = 2'd0;
    if (STORE_FIRST && req[0]) begin
      hit = 1'b1;
      win = 2'd0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        idx = ptr + 2'(k);
        if (!hit && req[idx]) begin
          hit = 1'b1;
          win = idx;
        end
      end
    end
  end

  // Gating with rst_n makes the command outputs drop at once on reset.
  assign go    = hit & rst_n;
  assign rd_go = go & (win != 2'd0);

  always_comb begin
    gnt      = 4'd0;
    mem_addr = '0;
    if (go) begin
      gnt = 4'b0001 << win;
      unique case (1'b1)
        (win == 2'd0): mem_addr = addr0;
        (win == 2'd1): mem_addr = addr1;
        (win == 2'd2): mem_addr = addr2;
        (win == 2'd3): mem_addr = addr3;
        default:       mem_addr = '0;
      endcase
    end
  end

  assign mem_en    = go;
  assign mem_we    = go & (win == 2'd0);
  assign mem_wdata = mem_we ? wdata0 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= 2'd0;
      pend_v   <= 1'b0;
      pend_tag <= 2'd0;
    end else begin
      if (go) begin
        ptr <= win + 2'd1;
      end
      pend_v   <= rd_go;
      pend_tag <= win;
    end
  end

  // pend_tag is never 0 while pend_v is set, since stores never read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 4'd0;
      rdata1 <= '0;
      rdata2 <= '0;
      rdata3 <= '0;
    end else begin
      rvalid <= 4'd0;
      if (pend_v) begin
        rvalid[pend_tag] <= 1'b1;
        unique case (1'b1)
          (pend_tag == 2'd1): rdata1 <= mem_rdata;
          (pend_tag == 2'd2): rdata2 <= mem_rdata;
          (pend_tag == 2'd3): rdata3 <= mem_rdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (round-robin store and
// store-first) share stimulus, each with its own memory and reference model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] addr [4];
  logic [15:0] wdata0;

  logic [3:0]  gnt    [2];
  logic [15:0] rdata1 [2];
  logic [15:0] rdata2 [2];
  logic [15:0] rdata3 [2];
  logic [3:0]  rvalid [2];
  logic        mem_en [2];
  logic        mem_we [2];
  logic [15:0] mem_addr  [2];
  logic [15:0] mem_wdata [2];
  logic [15:0] mem_rdata [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STORE_FIRST(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .addr0(addr[0]), .addr1(addr[1]), .addr2(addr[2]), .addr3(addr[3]),
    .wdata0(wdata0), .gnt(gnt[0]),
    .rdata1(rdata1[0]), .rdata2(rdata2[0]), .rdata3(rdata3[0]),
    .rvalid(rvalid[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0])
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STORE_FIRST(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .addr0(addr[0]), .addr1(addr[1]), .addr2(addr[2]), .addr3(addr[3]),
    .wdata0(wdata0), .gnt(gnt[1]),
    .rdata1(rdata1[1]), .rdata2(rdata2[1]), .rdata3(rdata3[1]),
    .rvalid(rvalid[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1])
  );

  // Environment memories: registered read, write at the clock edge.
  logic [15:0] mem [2][65536];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_en[d]) begin
        if (mem_we[d]) mem[d][mem_addr[d]] <= mem_wdata[d];
        else           mem_rdata[d] <= mem[d][mem_addr[d]];
      end
    end
  end

  // Reference model state.
  logic [15:0] m_mem [2][65536];
  int          m_ptr [2];
  logic        s_v   [2][4];
  int          s_tag [2][4];
  logic [15:0] s_dat [2][4];
  logic [15:0] m_rd  [2][4];
  bit          sf    [2];

  function automatic logic [15:0] init_val(input int a);
    return 16'(a) ^ 16'hA5C3;
  endfunction

  task automatic chk(input int d, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL d%0d %s cyc=%0d act=%h exp=%h", d, nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset(input int d);
    m_ptr[d] = 0;
    for (int i = 0; i < 4; i++) begin
      s_v[d][i]  = 1'b0;
      m_rd[d][i] = 16'h0;
    end
  endtask

  task automatic model_step(input int d);
    logic [3:0] eg;
    logic [3:0] erv;
    int w;
    int sl;
    int id;
    if (!rst_n) begin
      chk(d, "rst_gnt", 32'(gnt[d]), 32'h0);
      chk(d, "rst_en", 32'(mem_en[d]), 32'h0);
      chk(d, "rst_we", 32'(mem_we[d]), 32'h0);
      chk(d, "rst_rvalid", 32'(rvalid[d]), 32'h0);
      chk(d, "rst_rdata1", 32'(rdata1[d]), 32'h0);
      chk(d, "rst_rdata2", 32'(rdata2[d]), 32'h0);
      chk(d, "rst_rdata3", 32'(rdata3[d]), 32'h0);
      model_reset(d);
      return;
    end
    sl  = cyc % 4;
    erv = 4'd0;
    if (s_v[d][sl]) begin
      erv[s_tag[d][sl]] = 1'b1;
      m_rd[d][s_tag[d][sl]] = s_dat[d][sl];
      s_v[d][sl] = 1'b0;
    end
    w = -1;
    if (sf[d] && req[0]) w = 0;
    else begin
      for (int k = 0; k < 4; k++) begin
        id = (m_ptr[d] + k) % 4;
        if (w < 0 && req[id]) w = id;
      end
    end
    eg = (w < 0) ? 4'd0 : (4'd1 << w);
    chk(d, "gnt", 32'(gnt[d]), 32'(eg));
    chk(d, "mem_en", 32'(mem_en[d]), (w >= 0) ? 32'd1 : 32'd0);
    chk(d, "mem_we", 32'(mem_we[d]), (w == 0) ? 32'd1 : 32'd0);
    chk(d, "mem_wdata", 32'(mem_wdata[d]),
        (w == 0) ? 32'(wdata0) : 32'h0);
    if (w >= 0) chk(d, "mem_addr", 32'(mem_addr[d]), 32'(addr[w]));
    chk(d, "rvalid", 32'(rvalid[d]), 32'(erv));
    chk(d, "rdata1", 32'(rdata1[d]), 32'(m_rd[d][1]));
    chk(d, "rdata2", 32'(rdata2[d]), 32'(m_rd[d][2]));
    chk(d, "rdata3", 32'(rdata3[d]), 32'(m_rd[d][3]));
    if (w >= 0) begin
      m_ptr[d] = (w + 1) % 4;
      if (w == 0) m_mem[d][addr[0]] = wdata0;
      else begin
        sl = (cyc + 2) % 4;
        s_v[d][sl]   = 1'b1;
        s_tag[d][sl] = w;
        s_dat[d][sl] = m_mem[d][addr[w]];
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) model_step(d);
    cyc++;
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic lit_both(input string nm, input logic [3:0] e0,
                          input logic [3:0] e1);
    chk(0, nm, 32'(gnt[0]), 32'(e0));
    chk(1, nm, 32'(gnt[1]), 32'(e1));
  endtask

  task automatic do_reset();
    nxt();
    rst_n = 1'b0;
    repeat (2) nxt();
    rst_n = 1'b1;
  endtask

  initial begin
    sf[0] = 1'b0;
    sf[1] = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 65536; a++) begin
        mem[d][a]   = init_val(a);
        m_mem[d][a] = init_val(a);
      end
      mem[d][16'h3000]   = 16'h1234;
      m_mem[d][16'h3000] = 16'h1234;
      model_reset(d);
      mem_rdata[d] = 16'h0;
    end
    rst_n  = 1'b0;
    req    = 4'd0;
    wdata0 = 16'h0;
    for (int i = 0; i < 4; i++) addr[i] = 16'h0;
    repeat (2) nxt();
    rst_n = 1'b1;

    // reset state
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk(d, "init_rvalid", 32'(rvalid[d]), 32'h0);
      chk(d, "init_rdata1", 32'(rdata1[d]), 32'h0);
    end
    lit_both("init_gnt", 4'd0, 4'd0);

    // single fetch read
    nxt();
    req = 4'b0010;
    addr[1] = 16'h3000;
    @(negedge clk);
    lit_both("t1_gnt", 4'b0010, 4'b0010);
    nxt();
    req = 4'd0;
    @(negedge clk);
    chk(0, "t1_rv_c1", 32'(rvalid[0]), 32'h0);
    @(negedge clk);
    chk(0, "t1_rv_c2", 32'(rvalid[0]), 32'h2);
    chk(0, "t1_rdata1", 32'(rdata1[0]), 32'h1234);
    chk(1, "t1_rdata1", 32'(rdata1[1]), 32'h1234);
    @(negedge clk);
    chk(0, "t1_rv_c3", 32'(rvalid[0]), 32'h0);

    // all four requesting
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) addr[i] = 16'h0080 + 16'(i);
    wdata0 = 16'h5555;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      lit_both("t2_gnt", 4'd1 << (k % 4), 4'b0001);
      nxt();
    end
    req = 4'd0;

    // store override
    do_reset();
    req = 4'b1001;
    addr[3] = 16'h0090;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      lit_both("t3_gnt", (k == 1) ? 4'b1000 : 4'b0001, 4'b0001);
      nxt();
    end
    req = 4'b1000;
    @(negedge clk);
    lit_both("t3_gnt_ld2", 4'b1000, 4'b1000);
    nxt();

    // store then loads of the same address
    req = 4'b0001;
    addr[0] = 16'h0040;
    wdata0 = 16'hBEEF;
    @(negedge clk);
    lit_both("t4_st", 4'b0001, 4'b0001);
    nxt();
    req = 4'b0100;
    addr[2] = 16'h0040;
    @(negedge clk);
    lit_both("t4_ld1", 4'b0100, 4'b0100);
    nxt();
    req = 4'b0010;
    addr[1] = 16'h0040;
    @(negedge clk);
    lit_both("t4_fetch", 4'b0010, 4'b0010);
    nxt();
    req = 4'd0;
    @(negedge clk);
    chk(0, "t4_rv2", 32'(rvalid[0]), 32'h4);
    chk(0, "t4_rdata2", 32'(rdata2[0]), 32'hBEEF);
    @(negedge clk);
    chk(1, "t4_rv1", 32'(rvalid[1]), 32'h2);
    chk(1, "t4_rdata1", 32'(rdata1[1]), 32'hBEEF);

    // idle hold
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk(d, "idle_en", 32'(mem_en[d]), 32'h0);
        chk(d, "idle_rv", 32'(rvalid[d]), 32'h0);
        chk(d, "idle_rdata1", 32'(rdata1[d]), 32'hBEEF);
        chk(d, "idle_rdata2", 32'(rdata2[d]), 32'hBEEF);
        chk(d, "idle_rdata3", 32'(rdata3[d]), 32'(init_val(16'h0090)));
      end
      lit_both("idle_gnt", 4'd0, 4'd0);
    end

    // reset while a load2 read is in flight
    nxt();
    req = 4'b1000;
    addr[3] = 16'h0044;
    @(negedge clk);
    lit_both("t5_gnt", 4'b1000, 4'b1000);
    nxt();
    rst_n = 1'b0;
    #1;
    lit_both("t5_async_gnt", 4'd0, 4'd0);
    for (int d = 0; d < 2; d++) begin
      chk(d, "t5_async_en", 32'(mem_en[d]), 32'h0);
      chk(d, "t5_async_rdata3", 32'(rdata3[d]), 32'h0);
    end
    @(negedge clk);
    chk(0, "t5_rv", 32'(rvalid[0]), 32'h0);
    chk(1, "t5_rv", 32'(rvalid[1]), 32'h0);
    nxt();
    rst_n = 1'b1;
    req = 4'b1110;
    @(negedge clk);
    lit_both("t5_restart", 4'b0010, 4'b0010);
    nxt();
    req = 4'b1000;
    @(negedge clk);
    lit_both("t5_ld2", 4'b1000, 4'b1000);
    nxt();
    req = 4'd0;

    // randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      if (c % 400 == 399) begin
        rst_n = 1'b0;
        #1;
        lit_both("rnd_async_gnt", 4'd0, 4'd0);
        repeat (2) nxt();
        rst_n = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        if (req[i]) begin
          if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 4) < 2) begin
          req[i]  = 1'b1;
          addr[i] = 16'h0040 + 16'($urandom_range(0, 7));
          if (i == 0) wdata0 = 16'($urandom);
        end
      end
      nxt();
    end
    req = 4'd0;
    repeat (4) nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
